// File: rtl/bcd_time_countdown.sv
// bcd_time_countdown: HH:MM:SS packed-BCD countdown timer with load, start, pause and done pulse.
module bcd_time_countdown #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_ms_hr,
  input  logic [3:0] ld_ls_hr,
  input  logic [3:0] ld_ms_min,
  input  logic [3:0] ld_ls_min,
  input  logic [3:0] ld_ms_sec,
  input  logic [3:0] ld_ls_sec,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic [3:0] ms_sec,
  output logic [3:0] ls_sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);
  localparam int PW = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, EXPIRED = 2'd3;
  logic [1:0] state;
  logic [PW-1:0] pre;
  logic valid, zero, next_zero, tick;
  logic b0, b1, b2, b3, b4;
  logic [3:0] n_ms_hr, n_ls_hr, n_ms_min, n_ls_min, n_ms_sec, n_ls_sec;
  always_comb begin
    valid = ld_ms_hr <= 4'd2 && ld_ls_hr <= 4'd9 && (ld_ms_hr != 4'd2 || ld_ls_hr <= 4'd3) &&
            ld_ms_min <= 4'd5 && ld_ls_min <= 4'd9 && ld_ms_sec <= 4'd5 && ld_ls_sec <= 4'd9;
    zero = {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec} == 24'd0;
    tick = pre == PMAX && !zero;
    // borrow chain: each b flags that every lower digit wrapped
    b0 = ls_sec == 4'd0;
    b1 = b0 && ms_sec == 4'd0;
    b2 = b1 && ls_min == 4'd0;
    b3 = b2 && ms_min == 4'd0;
    b4 = b3 && ls_hr == 4'd0;
    n_ls_sec = b0 ? 4'd9 : ls_sec - 4'd1;
    n_ms_sec = !b0 ? ms_sec : b1 ? 4'd5 : ms_sec - 4'd1;
    n_ls_min = !b1 ? ls_min : b2 ? 4'd9 : ls_min - 4'd1;
    n_ms_min = !b2 ? ms_min : b3 ? 4'd5 : ms_min - 4'd1;
    n_ls_hr  = !b3 ? ls_hr : b4 ? 4'd9 : ls_hr - 4'd1;
    n_ms_hr  = b4 ? ms_hr - 4'd1 : ms_hr;
    next_zero = {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min, n_ms_sec, n_ls_sec} == 24'd0;
  end
  assign running = state == RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec} <= '0;
      state <= IDLE;
      pre <= '0;
      done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (valid) begin
          {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec} <=
            {ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min, ld_ms_sec, ld_ls_sec};
          state <= IDLE;
          pre <= '0;
        end else
          load_err <= 1'b1;
      end else if (state == IDLE) begin
        if (!pause && start) begin
          state <= zero ? EXPIRED : RUN;
          done <= zero;
          pre <= '0;
        end
      end else if (state == RUN) begin
        if (pause)
          state <= PAUSED;
        else if (tick) begin
          {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec} <=
            {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min, n_ms_sec, n_ls_sec};
          pre <= '0;
          if (next_zero) begin
            state <= EXPIRED;
            done <= 1'b1;
          end
        end else
          pre <= pre + 1'b1;
      end else if (state == PAUSED) begin
        if (!pause && start)
          state <= RUN;
      end
    end
  end
endmodule
